ifu_pc_gen: RTL and testbench



---
 rtl/ifu_pkg.sv | 19 +
 rtl/ifu_pc_gen.sv | 132 +++++++++++++
 tb/tb_ifu_pc_gen.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg
// Shared definitions for the instruction-fetch PC generator.
//   state_t  : fetch FSM state encoding (S_REQ / S_WAIT / S_HOLD)
//   RESET_PC : default fetch PC loaded by reset
//   INST_NOP : canonical NOP (addi x0,x0,0) used downstream for bubbles
// ---------------------------------------------------------------------------
package ifu_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/ifu_pc_gen.sv
// ---------------------------------------------------------------------------
// ifu_pc_gen
// Owns the architectural fetch PC, issues one instruction-memory request at a
// time and hands the fetched instruction plus its PC to the IF/ID register.
// A branch/jump redirect squashes whatever wrong-path work is in progress.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   pc_b_j, dnpc      : redirect request and target from the BJU
//   imem_req_*        : request channel to instruction memory (addr out)
//   imem_resp_*       : response channel from instruction memory (data in)
//   if_valid/if_ready : instruction hand-off to IF/ID, with if_pc / if_inst
//   fsm_state         : current fetch FSM state, for observation only
//
// Handshakes: every channel is valid/ready. A transfer happens on a rising
// edge where valid and ready are both 1. The address/data belonging to a
// valid is only meaningful while valid is 1.
// ---------------------------------------------------------------------------
module ifu_pc_gen #(
  parameter int                ADDR_W   = 64,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(ifu_pkg::RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_b_j,
  input  logic [ADDR_W-1:0] dnpc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  output logic              imem_resp_ready,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic [1:0]        fsm_state
);

  import ifu_pkg::*;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              drop;
  logic [ADDR_W-1:0] hold_pc;
  logic [INST_W-1:0] hold_inst;
  logic [ADDR_W-1:0] redirect_pc;

  // Targets are word aligned: the two low bits are ignored.
  assign redirect_pc = {dnpc[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      state     <= S_REQ;
      drop      <= 1'b0;
      hold_pc   <= '0;
      hold_inst <= '0;
    end else begin
      // Redirect wins over every other PC update below (last write wins).
      case (state)
        S_REQ: begin
          if (imem_req_ready) begin
            state <= S_WAIT;
            // Request issued with the old PC in the same cycle as a redirect:
            // its response belongs to the wrong path.
            drop  <= pc_b_j;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (drop || pc_b_j) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              hold_inst <= imem_resp_data;
              hold_pc   <= pc;
              pc        <= pc + ADDR_W'(4);
              state     <= S_HOLD;
            end
          end else if (pc_b_j) begin
            drop <= 1'b1;
          end
        end
        S_HOLD: begin
          // if_valid is masked by pc_b_j, so a redirect never transfers.
          if (pc_b_j || if_ready) begin
            state <= S_REQ;
          end
        end
        default: begin
          state <= S_REQ;
        end
      endcase
      if (pc_b_j) begin
        pc <= redirect_pc;
      end
    end
  end

  always_comb begin
    imem_req_valid  = 1'b0;
    imem_req_addr   = '0;
    imem_resp_ready = 1'b0;
    if_valid        = 1'b0;
    if_pc           = '0;
    if_inst         = '0;
    if (!rst) begin
      case (state)
        S_REQ: begin
          imem_req_valid = 1'b1;
          imem_req_addr  = pc;
        end
        S_WAIT: begin
          imem_resp_ready = 1'b1;
        end
        S_HOLD: begin
          if_valid = ~pc_b_j;
          if_pc    = hold_pc;
          if_inst  = hold_inst;
        end
        default: begin
          imem_req_valid = 1'b0;
        end
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_ifu_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_ifu_pc_gen
// Directed vector table, a hand-written reset-in-flight sequence and a
// randomized run against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_ifu_pc_gen;

  import ifu_pkg::*;

  localparam int ADDR_W = 64;
  localparam int INST_W = 32;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pc_b_j = 1'b0;
  logic [ADDR_W-1:0] dnpc = '0;
  logic              imem_req_valid;
  logic              imem_req_ready = 1'b0;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_resp_valid = 1'b0;
  logic              imem_resp_ready;
  logic [INST_W-1:0] imem_resp_data = '0;
  logic              if_valid;
  logic              if_ready = 1'b0;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic [1:0]        fsm_state;

  always #5 clk = ~clk;

  ifu_pc_gen #(
    .ADDR_W  (ADDR_W),
    .INST_W  (INST_W),
    .RESET_PC(64'h0000_0000_8000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_b_j         (pc_b_j),
    .dnpc           (dnpc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_ready(imem_resp_ready),
    .imem_resp_data (imem_resp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .fsm_state      (fsm_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs are changed 1ns after a rising edge; outputs sampled 3ns later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic rr, input logic rv, input logic [31:0] rd,
                        input logic ifr, input logic bj, input logic [63:0] tgt);
    imem_req_ready  = rr;
    imem_resp_valid = rv;
    imem_resp_data  = rd;
    if_ready        = ifr;
    pc_b_j          = bj;
    dnpc            = tgt;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " req_valid"},  64'(imem_req_valid),  64'd0);
    chk({tag, " req_addr"},   imem_req_addr,        64'd0);
    chk({tag, " resp_ready"}, 64'(imem_resp_ready), 64'd0);
    chk({tag, " if_valid"},   64'(if_valid),        64'd0);
    chk({tag, " if_pc"},      if_pc,                64'd0);
    chk({tag, " if_inst"},    64'(if_inst),         64'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rr;
    logic        rv;
    logic [31:0] rd;
    logic        ifr;
    logic        bj;
    logic [63:0] tgt;
    logic        e_rqv;
    logic [63:0] e_addr;
    logic        e_rsr;
    logic        e_ifv;
    logic [63:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic rr, input logic rv, input logic [31:0] rd,
                     input logic ifr, input logic bj, input logic [63:0] tgt,
                     input logic e_rqv, input logic [63:0] e_addr, input logic e_rsr,
                     input logic e_ifv, input logic [63:0] e_pc, input logic [31:0] e_inst);
    vec_t v;
    v.rr = rr; v.rv = rv; v.rd = rd; v.ifr = ifr; v.bj = bj; v.tgt = tgt;
    v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_rsr = e_rsr;
    v.e_ifv = e_ifv; v.e_pc = e_pc; v.e_inst = e_inst;
    vt.push_back(v);
  endtask

  task automatic fill_table();
    // Zero-wait fetch of three NOPs: one instruction every 3 cycles.
    for (int k = 0; k < 3; k++) begin
      add(1, 0, 0,        0, 0, 0, 1, 64'h8000_0000 + 64'(4 * k), 0, 0, 0, 0);
      add(0, 1, INST_NOP, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      add(0, 0, 0,        1, 0, 0, 0, 0, 0, 1, 64'h8000_0000 + 64'(4 * k), INST_NOP);
    end
    // IF/ID stalls for 5 cycles: outputs stable, no new request.
    add(1, 0, 0,            0, 0, 0, 1, 64'h8000_000C, 0, 0, 0, 0);
    add(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++)
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h8000_000C, 32'hDEAD_BEEF);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 64'h8000_000C, 32'hDEAD_BEEF);
    // Redirect in S_WAIT, response 3 cycles later is dropped.
    add(1, 0, 0,            0, 0, 0,             1, 64'h8000_0010, 0, 0, 0, 0);
    add(0, 0, 0,            0, 1, 64'h8000_0100, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0,            0, 0, 0,             0, 0, 1, 0, 0, 0);
    add(0, 0, 0,            0, 0, 0,             0, 0, 1, 0, 0, 0);
    add(0, 1, 32'h1111_1111, 1, 0, 0,             0, 0, 1, 0, 0, 0);
    add(1, 0, 0,            1, 0, 0,             1, 64'h8000_0100, 0, 0, 0, 0);
    // Redirect in S_HOLD with if_ready=1: no transfer.
    add(0, 1, 32'h2222_2222, 0, 0, 0,             0, 0, 1, 0, 0, 0);
    add(0, 0, 0,            1, 1, 64'h8000_0200, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,            0, 0, 0,             1, 64'h8000_0200, 0, 0, 0, 0);
    add(1, 0, 0,            0, 0, 0,             1, 64'h8000_0200, 0, 0, 0, 0);
    add(0, 1, 32'h3333_3333, 0, 0, 0,             0, 0, 1, 0, 0, 0);
    add(0, 0, 0,            1, 0, 0,             0, 0, 0, 1, 64'h8000_0200, 32'h3333_3333);
    // Back-to-back redirects (last wins, low bits forced), second one
    // coincides with a request handshake at 0x80000004.
    add(0, 0, 0,            0, 1, 64'h8000_0004, 1, 64'h8000_0204, 0, 0, 0, 0);
    add(1, 0, 0,            0, 1, 64'h8000_0303, 1, 64'h8000_0004, 0, 0, 0, 0);
    add(0, 1, 32'h4444_4444, 1, 0, 0,             0, 0, 1, 0, 0, 0);
    add(1, 0, 0,            1, 0, 0,             1, 64'h8000_0300, 0, 0, 0, 0);
    add(0, 1, 32'h5555_5555, 0, 0, 0,             0, 0, 1, 0, 0, 0);
    add(0, 0, 0,            1, 0, 0,             0, 0, 0, 1, 64'h8000_0300, 32'h5555_5555);
    // PC increment wraps at the top of the address space.
    add(0, 0, 0,            0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 64'h8000_0304, 0, 0, 0, 0);
    add(1, 0, 0,            0, 0, 0,             1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0);
    add(0, 1, 32'h6666_6666, 0, 0, 0,             0, 0, 1, 0, 0, 0);
    add(0, 0, 0,            1, 0, 0,             0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h6666_6666);
    add(0, 0, 0,            0, 0, 0,             1, 64'h0, 0, 0, 0, 0);
  endtask

  task automatic run_table();
    for (int i = 0; i < vt.size(); i++) begin
      set_in(vt[i].rr, vt[i].rv, vt[i].rd, vt[i].ifr, vt[i].bj, vt[i].tgt);
      #3;
      chk($sformatf("row%0d req_valid", i), 64'(imem_req_valid), 64'(vt[i].e_rqv));
      if (vt[i].e_rqv)
        chk($sformatf("row%0d req_addr", i), imem_req_addr, vt[i].e_addr);
      chk($sformatf("row%0d resp_ready", i), 64'(imem_resp_ready), 64'(vt[i].e_rsr));
      chk($sformatf("row%0d if_valid", i), 64'(if_valid), 64'(vt[i].e_ifv));
      if (vt[i].e_ifv) begin
        chk($sformatf("row%0d if_pc", i), if_pc, vt[i].e_pc);
        chk($sformatf("row%0d if_inst", i), 64'(if_inst), 64'(vt[i].e_inst));
      end
      next_cycle();
    end
  endtask

  // ---------------- reference model for random phase ----------------
  // Transaction view: a request is either outstanding or not, it may be
  // marked stale, and at most one instruction is held for IF/ID.
  logic [63:0] m_pc;
  bit          m_pending, m_stale, m_have;
  logic [63:0] m_hold_pc;
  logic [31:0] m_hold_inst;
  // Memory responder: one outstanding access with a random latency.
  bit          mem_busy;
  int          mem_delay;
  logic [31:0] mem_data;

  task automatic run_random(input int cycles);
    bit          rr, rv, ifr, bj, hs, have_before;
    logic [31:0] rd;
    logic [63:0] tgt;
    for (int c = 0; c < cycles; c++) begin
      rr  = ($urandom_range(0, 3) != 0);
      ifr = ($urandom_range(0, 3) != 0);
      bj  = ($urandom_range(0, 9) == 0);
      tgt = {$urandom, $urandom};
      rv  = mem_busy && (mem_delay == 0);
      rd  = rv ? mem_data : $urandom;
      set_in(rr, rv, rd, ifr, bj, tgt);
      #3;
      chk("rnd req_valid", 64'(imem_req_valid), 64'(!m_pending && !m_have));
      if (!m_pending && !m_have)
        chk("rnd req_addr", imem_req_addr, m_pc);
      chk("rnd resp_ready", 64'(imem_resp_ready), 64'(m_pending));
      chk("rnd if_valid", 64'(if_valid), 64'(m_have && !bj));
      if (m_have && !bj) begin
        chk("rnd if_pc", if_pc, m_hold_pc);
        chk("rnd if_inst", 64'(if_inst), 64'(m_hold_inst));
      end
      // Advance the model by one clock using this cycle's inputs.
      hs          = !m_pending && !m_have && rr;
      have_before = m_have;
      if (mem_busy) begin
        if (rv) mem_busy = 0;
        else    mem_delay--;
      end
      if (m_pending && rv) begin
        m_pending = 0;
        if (!(m_stale || bj)) begin
          m_have      = 1;
          m_hold_pc   = m_pc;
          m_hold_inst = rd;
          m_pc        = m_pc + 64'd4;
        end
        m_stale = 0;
      end else if (m_pending && bj) begin
        m_stale = 1;
      end
      if (hs) begin
        m_pending = 1;
        m_stale   = bj;
        mem_busy  = 1;
        mem_delay = $urandom_range(0, 3);
        mem_data  = $urandom;
      end
      if (have_before && (bj || ifr)) m_have = 0;
      if (bj) m_pc = tgt & ~64'd3;
      next_cycle();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    set_in(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    next_cycle();
    chk_all_zero("in_reset");
    next_cycle();
    chk("reset fsm_state", 64'(fsm_state), 64'(S_REQ));
    rst = 1'b0;

    fill_table();
    run_table();

    // Reset asserted while a request is outstanding.
    set_in(1, 0, 0, 0, 0, 0);
    #3;
    chk("rst_seq req_addr", imem_req_addr, 64'h0);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0);
    #3;
    chk("rst_seq wait resp_ready", 64'(imem_resp_ready), 64'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("rst_seq asserted");
    next_cycle();
    chk_all_zero("rst_seq held");
    chk("rst_seq fsm_state", 64'(fsm_state), 64'(S_REQ));
    rst = 1'b0;
    #3;
    chk("rst_seq release req_valid", 64'(imem_req_valid), 64'd1);
    chk("rst_seq release req_addr", imem_req_addr, 64'h8000_0000);
    set_in(1, 0, 0, 0, 0, 0);
    next_cycle();
    set_in(0, 1, 32'h7777_7777, 0, 0, 0);
    next_cycle();
    set_in(0, 0, 0, 1, 0, 0);
    #3;
    chk("rst_seq if_valid", 64'(if_valid), 64'd1);
    chk("rst_seq if_pc", if_pc, 64'h8000_0000);
    chk("rst_seq if_inst", 64'(if_inst), 64'h7777_7777);
    next_cycle();

    // Random phase starts from S_REQ with pc = 0x80000004.
    m_pc      = 64'h8000_0004;
    m_pending = 0;
    m_stale   = 0;
    m_have    = 0;
    m_hold_pc = '0;
    m_hold_inst = '0;
    mem_busy  = 0;
    mem_delay = 0;
    mem_data  = '0;
    run_random(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
